// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU with a start/ready handshake.
// Produces {remainder, quotient}; operations can be cancelled with annul.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 div_start,
   input  logic                 signed_div,
   input  logic [WIDTH-1:0]     opdata1,
   input  logic [WIDTH-1:0]     opdata2,
   input  logic                 annul,
   output logic [2*WIDTH-1:0]   result,
   output logic                 div_ready
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_t;

   state_t             state_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [WIDTH-1:0]   rem_reg;
   logic [WIDTH-1:0]   quo_reg;
   logic [WIDTH-1:0]   divisor_reg;
   logic [WIDTH-1:0]   dividend_reg;
   logic               qneg_reg;
   logic               rneg_reg;

   logic [WIDTH-1:0]   op1_abs;
   logic [WIDTH-1:0]   op2_abs;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   rem_final;
   logic [WIDTH-1:0]   quo_final;

   // Magnitudes of the operands; the most negative value maps onto itself,
   // which is exactly its unsigned magnitude.
   always_comb begin
      op1_abs = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
      op2_abs = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;
   end

   // One restoring step: bring in the next dividend bit and try to subtract.
   always_comb begin
      rem_shift = {rem_reg, quo_reg[WIDTH-1]};
      diff      = rem_shift - {1'b0, divisor_reg};
      rem_final = rneg_reg ? (~rem_reg + 1'b1) : rem_reg;
      quo_final = qneg_reg ? (~quo_reg + 1'b1) : quo_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         cnt_reg      <= '0;
         rem_reg      <= '0;
         quo_reg      <= '0;
         divisor_reg  <= '0;
         dividend_reg <= '0;
         qneg_reg     <= 1'b0;
         rneg_reg     <= 1'b0;
         result       <= '0;
         div_ready    <= 1'b0;
      end else begin
         div_ready <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (div_start && !annul) begin
                  cnt_reg      <= '0;
                  rem_reg      <= '0;
                  quo_reg      <= op1_abs;
                  divisor_reg  <= op2_abs;
                  dividend_reg <= opdata1;
                  qneg_reg     <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                  rneg_reg     <= signed_div & opdata1[WIDTH-1];
                  state_reg    <= (opdata2 == '0) ? S_BYZERO : S_ON;
               end
            end
            S_BYZERO: begin
               if (annul || !div_start) begin
                  state_reg <= S_IDLE;
               end else begin
                  result    <= {dividend_reg, {WIDTH{1'b1}}};
                  div_ready <= 1'b1;
                  state_reg <= S_END;
               end
            end
            S_ON: begin
               if (annul || !div_start) begin
                  state_reg <= S_IDLE;
               end else if (cnt_reg == CNT_W'(WIDTH)) begin
                  result    <= {rem_final, quo_final};
                  div_ready <= 1'b1;
                  state_reg <= S_END;
               end else begin
                  if (!diff[WIDTH]) begin
                     rem_reg <= diff[WIDTH-1:0];
                     quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
                  end else begin
                     rem_reg <= rem_shift[WIDTH-1:0];
                     quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
                  end
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_END: begin
               // A start still asserted here belongs to the op just finished.
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random DIV/DIVU
// traffic against an arithmetic reference model.
module tb_div_unit;

   logic         clk = 1'b0;
   logic         rst;
   logic         div_start;
   logic         signed_div;
   logic [31:0]  opdata1;
   logic [31:0]  opdata2;
   logic         annul;
   logic [63:0]  result;
   logic         div_ready;

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] last_res;

   div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .div_start  (div_start),
      .signed_div (signed_div),
      .opdata1    (opdata1),
      .opdata2    (opdata2),
      .annul      (annul),
      .result     (result),
      .div_ready  (div_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division (truncating toward zero), 64-bit wide
   // so the most-negative / -1 case wraps naturally when cut to 32 bits.
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub, uq, ur;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         sq = sa / sb;
         sr = sa % sb;
         return {sr[31:0], sq[31:0]};
      end
      ua = {32'd0, a};
      ub = {32'd0, b};
      uq = ua / ub;
      ur = ua % ub;
      return {ur[31:0], uq[31:0]};
   endfunction

   // Issue one op (start held like the hazard unit does) and check latency,
   // result and single-cycle ready.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit keep_start);
      int k;
      bit got;
      logic [63:0] exp_res;
      int exp_lat;
      exp_res    = ref_div(sgn, a, b);
      exp_lat    = (b == 32'd0) ? 2 : 34;
      div_start  = 1'b1;
      signed_div = sgn;
      opdata1    = a;
      opdata2    = b;
      k   = 0;
      got = 1'b0;
      while (!got && k < 100) begin
         @(negedge clk);
         k++;
         if (div_ready) got = 1'b1;
      end
      check({tag, " latency"}, 64'(k), 64'(exp_lat));
      check({tag, " result"}, result, exp_res);
      last_res = exp_res;
      if (!keep_start) div_start = 1'b0;
      @(negedge clk);
      check({tag, " ready pulse"}, 64'(div_ready), 64'd0);
      $display("op %s sgn=%0d a=%h b=%h -> %h (%0d cycles)", tag, sgn, a, b, result, k);
   endtask

   task automatic count_ready(input int cycles, output int seen);
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (div_ready) seen++;
      end
   endtask

   initial begin
      int seen;
      logic sgn;
      logic [31:0] a, b;
      rst = 1'b1; div_start = 1'b0; signed_div = 1'b0;
      opdata1 = '0; opdata2 = '0; annul = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset ready", 64'(div_ready), 64'd0);
      check("reset result", result, 64'd0);
      last_res = 64'd0;

      run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 1'b0);
      check("divu 100/7 value", result, {32'd2, 32'd14});
      run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("div -7/2 value", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
      check("div 7/-2 value", result, {32'd1, 32'hFFFF_FFFD});
      run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("div min/-1 value", result, {32'd0, 32'h8000_0000});
      run_div("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("divu min/max value", result, {32'h8000_0000, 32'd0});
      run_div("div by zero", 1'b1, 32'h1234, 32'd0, 1'b0);
      check("div by zero value", result, {32'h1234, 32'hFFFF_FFFF});

      // Back-to-back with start held high through the ready cycle.
      run_div("b2b 9/3", 1'b0, 32'd9, 32'd3, 1'b1);
      run_div("b2b 10/4", 1'b0, 32'd10, 32'd4, 1'b0);
      check("b2b 10/4 value", result, {32'd2, 32'd2});

      // Annul at iteration ~10: no ready, result untouched.
      div_start = 1'b1; signed_div = 1'b0; opdata1 = 32'd500; opdata2 = 32'd3;
      repeat (11) @(negedge clk);
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0; div_start = 1'b0;
      count_ready(40, seen);
      check("annul no ready", 64'(seen), 64'd0);
      check("annul result held", result, last_res);

      // Reset mid-op on a new operation.
      div_start = 1'b1; opdata1 = 32'd77; opdata2 = 32'd5;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; div_start = 1'b0;
      check("midop reset result", result, 64'd0);
      check("midop reset ready", 64'(div_ready), 64'd0);
      last_res = 64'd0;
      count_ready(40, seen);
      check("midop reset no ready", 64'(seen), 64'd0);

      // Start withdrawn mid-op.
      div_start = 1'b1; opdata1 = 32'd1000; opdata2 = 32'd9;
      repeat (5) @(negedge clk);
      div_start = 1'b0;
      count_ready(40, seen);
      check("start drop no ready", 64'(seen), 64'd0);
      check("start drop result held", result, last_res);

      // Annul held in IDLE blocks any start.
      annul = 1'b1; div_start = 1'b1; opdata2 = 32'd3;
      count_ready(40, seen);
      check("idle annul blocks", 64'(seen), 64'd0);
      annul = 1'b0; div_start = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = $urandom_range(1, 16);
            3:       b = a;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
         run_div($sformatf("rand%0d", i), sgn, a, b, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
